gate_result_fifo: RTL

GATE_RESULT_FIFO -- requirements
Module: gate_result_fifo

---
 rtl/gate_pkg.sv | 13 +
 rtl/gate_result_fifo_sat_counter.sv | 24 ++
 rtl/gate_result_fifo.sv | 105 ++++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// Shared types and defaults for the gate result FIFO.
package gate_pkg;

    // One gate-stage result: AND output (y1) and OR output (y2).
    typedef struct packed {
        logic y1;
        logic y2;
    } gate_res_t;

    localparam int unsigned GATE_FIFO_DEPTH_DEF = 4;
    localparam int unsigned GATE_CNT_W_DEF      = 8;

endpackage : gate_pkg

// File: rtl/gate_result_fifo_sat_counter.sv
// Saturating up-counter used for the gate result statistics.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;

    // Count increments and stick at the all-ones maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else if (inc && (value_q != {W{1'b1}})) begin
            value_q <= value_q + W'(1);
        end
    end

    assign value = value_q;

endmodule : sat_counter

// File: rtl/gate_result_fifo.sv
// First-word fall-through FIFO for (AND, OR) gate results with optional
// ones-statistics. Build macro: GATE_RESULT_FIFO_STATS_EN enables counters.
module gate_result_fifo
    import gate_pkg::*;
#(
    parameter int unsigned DEPTH = GATE_FIFO_DEPTH_DEF,
    parameter int unsigned CNT_W = GATE_CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_y1,
    input  logic                     in_y2,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_y1,
    output logic                     out_y2,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         y1_ones,
    output logic [CNT_W-1:0]         y2_ones
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = PTR_W + 1;

    gate_res_t             mem_q [DEPTH];
    gate_res_t             in_res;
    gate_res_t             head_q, head_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]   count_q, count_d;
    logic                  in_ready_q, out_valid_q;
    logic                  push, pop;

    assign in_res = gate_res_t'({in_y1, in_y2});
    assign push   = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    // Next pointers, occupancy and head entry; head holds when the FIFO drains.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_BITS'(push) - CNT_BITS'(pop);
        head_d   = head_q;
        if (push && (count_q == CNT_BITS'(pop))) begin
            // Incoming entry becomes the head because nothing else remains.
            head_d = in_res;
        end else if (count_d != '0) begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Entry storage; written on every accepted push.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= in_res;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= (count_d != CNT_BITS'(DEPTH));
            out_valid_q <= (count_d != '0);
            head_q      <= head_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_y1    = head_q.y1;
    assign out_y2    = head_q.y2;
    assign count     = count_q;

`ifdef GATE_RESULT_FIFO_STATS_EN
    sat_counter #(.W(CNT_W)) u_y1_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (push & in_y1),
        .value (y1_ones)
    );

    sat_counter #(.W(CNT_W)) u_y2_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (push & in_y2),
        .value (y2_ones)
    );
`else
    assign y1_ones = '0;
    assign y2_ones = '0;
`endif

endmodule : gate_result_fifo
